alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle initiator that drives the combinational ALU in the ControlUnit. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4-entry register file. It presents operands and opcode to the ALU, captures the ALU result and flags, writes the result back, and updates a sticky status-flag register. It sits between instruction fetch/decode and the ALU.

Parameters:
width, 4, datapath width; must match the ALU width parameter; legal range is 2 or greater.

Ports:
clk  in  1  system clock; rising edge.
rst  in  1  asynchronous, active-high reset.
instr_valid  in  1  an instruction is offered.
instr_ready  out  1  the sequencer can accept an instruction.
instr_op  in  4  opcode.
instr_rd  in  2  destination register index.
instr_ra  in  2  source A register index.
instr_rb  in  2  source B register index.
instr_imm  in  width  immediate value, used by LDI only.
alu_a  out  width  ALU operand A; registered.
alu_b  out  width  ALU operand B; registered.
alu_sel  out  4  ALU select; registered.
alu_result  in  width  ALU result.
alu_cout  in  1  ALU carry.
alu_negative  in  1  ALU negative flag.
alu_zero  in  1  ALU zero flag.
flag_c  out  1  stored carry flag.
flag_n  out  1  stored negative flag.
flag_z  out  1  stored zero flag.
done  out  1  one-cycle pulse: writeback complete.
err  out  1  one-cycle pulse: illegal opcode.
dbg_addr  in  2  register-file read address for debug.
dbg_data  out  width  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (asynchronous, active-high):
  - regfile[0..3]=0, alu_a=0, alu_b=0, alu_sel=0.
  - flag_c/n/z=0, done=0, err=0.
  - state=IDLE; instr_ready=1 on the first cycle after reset deasserts.
- instr_ready=1 only in IDLE.
- An instruction is accepted on a rising edge with instr_valid&instr_ready. The op, rd, ra, rb and imm fields are captured on that edge.
- Opcode map:
  - 0000 ADD, 0001 SUB, 0010 NOT A, 0011 AND, 0100 OR, 0101 XOR.
  - 0110 arithmetic shift left, 0111 logical shift left.
  - 1000 arithmetic shift right, 1001 logical shift right.
  - 1111 LDI.
  - 1010-1110 are illegal.
- States: IDLE, ISSUE, CAPTURE.
- ALU op, accepted at edge T:
  - Cycle T+1 is ISSUE. alu_a=regfile[ra], alu_b=regfile[rb], alu_sel=op.
  - Cycle T+2 is CAPTURE. The ALU outputs are sampled at the end of T+2: regfile[rd]<=alu_result, flag_c<=alu_cout, flag_n<=alu_negative, flag_z<=alu_zero.
  - done=1 during T+3, and state returns to IDLE at T+3 (instr_ready=1).
  - Throughput is one instruction per 3 cycles.
- LDI:
  - The T+1 edge goes to CAPTURE without driving the ALU; alu_* hold their previous values.
  - regfile[rd]<=instr_imm at the end of T+1; done=1 in T+2. Flags are unchanged.
- Illegal opcode:
  - The sequencer stays in IDLE. err=1 in T+1.
  - No register or flag write; alu_* unchanged. instr_ready stays 1, so back-to-back acceptance is allowed.
- Operand rules:
  - ra==rd or rb==rd is legal. Operands are read in ISSUE, before the write in CAPTURE.
  - ra==rb is legal.
- Flags follow the ALU rules: carry is meaningful only for ADD, negative only for SUB, zero for all ALU ops. They are stored exactly as the ALU reports them, with no masking.
- No arithmetic occurs inside the sequencer; widths are carried through unchanged.
- instr_valid while instr_ready=0 is ignored; the initiator must hold the instruction.
- Reset mid-instruction aborts it immediately: no write, no done, all values return to reset values.
- done and err are never high in the same cycle.

Decomposition:
- Package alu_seq_pkg:
  - Enum opcode_t: OP_ADD..OP_RSHIFT, OP_LDI=4'b1111.
  - Enum state_t: IDLE, ISSUE, CAPTURE.
  - Function is_legal_op().
- One sub-module, alu_seq_regfile: 4 x width registers, async reset, one write port, three combinational read ports (ra, rb, dbg).
- The bench instantiates alu_sequencer together with the real ALU.

Test Plan:
- Reset then LDI r1=3, LDI r2=5; ADD r3=r1+r2 -> dbg r3=8; flag_c=0, flag_z=0; done 3 cycles after ADD acceptance.
- LDI r1=4'hF, r2=4'h1; ADD r0=r1+r2 -> r0=0, flag_c=1, flag_z=1.
- LDI r1=2, r2=5; SUB r3=r1-r2 -> flag_n=1 and r3 equals the ALU magnitude output (3); then AND r0=r1&r2 -> r0=0, flag_z=1, flag_n=0.
- In-place op: r2=4'b0110, LSR r2=r2 -> r2=4'b0011; instr_ready low for exactly 2 cycles after acceptance.
- Illegal op 1100 with r0=7 -> err pulse in the next cycle, no done; r0 and flags unchanged; the next valid instruction is accepted in that same cycle.
- rst asserted during CAPTURE of ADD r3 -> outputs clear asynchronously; r3=0, done never pulses, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode/state types and opcode legality helper for the ALU sequencer
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_NOT    = 4'b0010,
        OP_AND    = 4'b0011,
        OP_OR     = 4'b0100,
        OP_XOR    = 4'b0101,
        OP_ASHL   = 4'b0110,
        OP_LSHL   = 4'b0111,
        OP_ASHR   = 4'b1000,
        OP_RSHIFT = 4'b1001,
        OP_LDI    = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // 1010..1110 are the only holes in the opcode map.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= 4'b1001) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction handshake and ALU operand/result bundle
interface alu_sequencer_if #(parameter int width = 4);

    logic             instr_valid;
    logic             instr_ready;
    logic [3:0]       instr_op;
    logic [1:0]       instr_rd;
    logic [1:0]       instr_ra;
    logic [1:0]       instr_rb;
    logic [width-1:0] instr_imm;
    logic [width-1:0] alu_a;
    logic [width-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [width-1:0] alu_result;
    logic             alu_cout;
    logic             alu_negative;
    logic             alu_zero;

    // master: fetch/decode plus the ALU it feeds; slave: the sequencer itself
    modport master (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        input  instr_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_cout, alu_negative, alu_zero
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        output instr_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_cout, alu_negative, alu_zero
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 4-entry register file, one write port, three combinational reads
module alu_seq_regfile #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       wa,
    input  logic [width-1:0] wd,
    input  logic [1:0]       ra_addr,
    output logic [width-1:0] ra_data,
    input  logic [1:0]       rb_addr,
    output logic [width-1:0] rb_data,
    input  logic [1:0]       dbg_addr,
    output logic [width-1:0] dbg_data
);

    logic [width-1:0] regs [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle initiator: regfile operands to ALU, result/flags writeback
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   bus,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_z,
    output logic             done,
    output logic             err,
    input  logic [1:0]       dbg_addr,
    output logic [width-1:0] dbg_data
);

    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic [1:0]       rd_q;
    logic [width-1:0] imm_q;
    logic [width-1:0] alu_a_q, alu_b_q;
    logic [3:0]       alu_sel_q;
    logic [width-1:0] rf_a, rf_b, rf_wd;

    logic accept, legal, is_ldi;
    logic ready_c, issue_load, cap_load, rf_we, flag_we, done_nxt, err_nxt;

    assign legal  = is_legal_op(bus.instr_op);
    assign is_ldi = (bus.instr_op == OP_LDI);
    assign accept = bus.instr_valid && ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Illegal opcodes never leave IDLE, so the next instruction can follow at once.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && legal) state_nxt = is_ldi ? CAPTURE : ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_c    = (state == IDLE);
        cap_load   = accept && legal;
        issue_load = accept && legal && !is_ldi;
        rf_we      = (state == CAPTURE);
        rf_wd      = (op_q == OP_LDI) ? imm_q : bus.alu_result;
        flag_we    = (state == CAPTURE) && (op_q != OP_LDI);
        done_nxt   = (state == CAPTURE);
        err_nxt    = accept && !legal;
    end

    // Operands are latched on the accept edge so the ALU sees them throughout ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (cap_load) begin
                op_q  <= bus.instr_op;
                rd_q  <= bus.instr_rd;
                imm_q <= bus.instr_imm;
            end
            if (issue_load) begin
                alu_a_q   <= rf_a;
                alu_b_q   <= rf_b;
                alu_sel_q <= bus.instr_op;
            end
            if (flag_we) begin
                flag_c <= bus.alu_cout;
                flag_n <= bus.alu_negative;
                flag_z <= bus.alu_zero;
            end
            done <= done_nxt;
            err  <= err_nxt;
        end
    end

    assign bus.instr_ready = ready_c;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_sel     = alu_sel_q;

    alu_seq_regfile #(.width(width)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .wa       (rd_q),
        .wd       (rf_wd),
        .ra_addr  (bus.instr_ra),
        .ra_data  (rf_a),
        .rb_addr  (bus.instr_rb),
        .rb_data  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - bench for alu_sequencer with a behavioural ALU and reference model
module tb_alu_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         fc, fn, fz, done, err;
    logic [1:0]   dbg_addr;
    logic [W-1:0] dbg_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.width(W)) bus ();

    alu_sequencer #(.width(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flag_c   (fc),
        .flag_n   (fn),
        .flag_z   (fz),
        .done     (done),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         n;
        logic         z;
    } alu_out_t;

    // The ALU: SUB reports magnitude plus a negative flag, shifts move by one place.
    function automatic alu_out_t alu_f(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_out_t   o;
        logic [W:0] s;
        o = '0;
        case (sel)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; o.res = s[W-1:0]; o.c = s[W]; end
            4'd1: if (a >= b) o.res = a - b; else begin o.res = b - a; o.n = 1'b1; end
            4'd2: o.res = ~a;
            4'd3: o.res = a & b;
            4'd4: o.res = a | b;
            4'd5: o.res = a ^ b;
            4'd6, 4'd7: o.res = a << 1;
            4'd8: o.res = {a[W-1], a[W-1:1]};
            4'd9: o.res = a >> 1;
            default: o.res = '0;
        endcase
        o.z = (o.res == '0);
        return o;
    endfunction

    alu_out_t alu_o;
    always_comb begin
        alu_o            = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
        bus.alu_result   = alu_o.res;
        bus.alu_cout     = alu_o.c;
        bus.alu_negative = alu_o.n;
        bus.alu_zero     = alu_o.z;
    end

    logic [W-1:0] m_rf [4];
    logic         m_c, m_n, m_z;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        m_c = 0; m_n = 0; m_z = 0;
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [1:0] rd, ra, rb, input logic [W-1:0] imm);
        alu_out_t o;
        if (op == 4'hF) begin
            m_rf[rd] = imm;
        end else if (op <= 4'd9) begin
            o = alu_f(op, m_rf[ra], m_rf[rb]);
            m_rf[rd] = o.res;
            m_c = o.c; m_n = o.n; m_z = o.z;
        end
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [W-1:0] val);
        dbg_addr = idx;
        #1;
        val = dbg_data;
    endtask

    // Issues one instruction and observes four cycles after acceptance.
    task automatic send(input logic [3:0] op, input logic [1:0] rd, ra, rb, input logic [W-1:0] imm,
                        output int done_at, output int err_at, output int busy, output int clash);
        int waited = 0;
        done_at = 0; err_at = 0; busy = 0; clash = 0;
        @(negedge clk);
        bus.instr_op = op; bus.instr_rd = rd; bus.instr_ra = ra; bus.instr_rb = rb;
        bus.instr_imm = imm; bus.instr_valid = 1'b1;
        while (bus.instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++; errors++;
            $display("FAIL accept_timeout instr_ready=%b required 1", bus.instr_ready);
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1 && done_at == 0) done_at = k;
            if (err === 1'b1 && err_at == 0) err_at = k;
            if (done === 1'b1 && err === 1'b1) clash++;
            if (bus.instr_ready !== 1'b1) busy++;
        end
        model_exec(op, rd, ra, rb, imm);
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        rst = 1'b1;
        bus.instr_valid = 0; bus.instr_op = 0; bus.instr_rd = 0; bus.instr_ra = 0;
        bus.instr_rb = 0; bus.instr_imm = 0; dbg_addr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
        checks++; if ({fc, fn, fz} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {fc, fn, fz}); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin errors++; $display("FAIL reset_alu got=%h exp=0", {bus.alu_a, bus.alu_b, bus.alu_sel}); end
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            checks++; if (v !== '0) begin errors++; $display("FAIL reset_r%0d got=%h exp=0", i, v); end
        end
    endtask

    task automatic test_ldi_add();
        int d, e, b, c;
        logic [W-1:0] v;
        send(4'hF, 2'd1, 2'd0, 2'd0, 4'd3, d, e, b, c);
        checks++; if (d != 2 || b != 1) begin errors++; $display("FAIL ldi_timing got done@%0d busy=%0d exp done@2 busy=1", d, b); end
        send(4'hF, 2'd2, 2'd0, 2'd0, 4'd5, d, e, b, c);
        send(4'h0, 2'd3, 2'd1, 2'd2, 4'd0, d, e, b, c);
        checks++; if (d != 3 || b != 2 || e != 0) begin errors++; $display("FAIL add_timing got done@%0d busy=%0d err@%0d exp 3 2 0", d, b, e); end
        read_reg(2'd3, v);
        checks++; if (v !== 4'd8) begin errors++; $display("FAIL add_r3 got=%h exp=8", v); end
        checks++; if ({fc, fz} !== 2'b00) begin errors++; $display("FAIL add_flags got cz=%b exp=00", {fc, fz}); end
    endtask

    task automatic test_add_carry();
        int d, e, b, c;
        logic [W-1:0] v;
        send(4'hF, 2'd1, 2'd0, 2'd0, 4'hF, d, e, b, c);
        send(4'hF, 2'd2, 2'd0, 2'd0, 4'h1, d, e, b, c);
        send(4'h0, 2'd0, 2'd1, 2'd2, 4'd0, d, e, b, c);
        read_reg(2'd0, v);
        checks++; if (v !== 4'd0) begin errors++; $display("FAIL carry_r0 got=%h exp=0", v); end
        checks++; if ({fc, fz} !== 2'b11) begin errors++; $display("FAIL carry_flags got cz=%b exp=11", {fc, fz}); end
    endtask

    task automatic test_sub_and();
        int d, e, b, c;
        logic [W-1:0] v;
        send(4'hF, 2'd1, 2'd0, 2'd0, 4'd2, d, e, b, c);
        send(4'hF, 2'd2, 2'd0, 2'd0, 4'd5, d, e, b, c);
        send(4'h1, 2'd3, 2'd1, 2'd2, 4'd0, d, e, b, c);
        read_reg(2'd3, v);
        checks++; if (v !== 4'd3) begin errors++; $display("FAIL sub_r3 got=%h exp=3", v); end
        checks++; if (fn !== 1'b1) begin errors++; $display("FAIL sub_neg got=%b exp=1", fn); end
        send(4'h3, 2'd0, 2'd1, 2'd2, 4'd0, d, e, b, c);
        read_reg(2'd0, v);
        checks++; if (v !== 4'd0) begin errors++; $display("FAIL and_r0 got=%h exp=0", v); end
        checks++; if ({fz, fn} !== 2'b10) begin errors++; $display("FAIL and_flags got zn=%b exp=10", {fz, fn}); end
    endtask

    task automatic test_inplace();
        int d, e, b, c;
        logic [W-1:0] v;
        send(4'hF, 2'd2, 2'd0, 2'd0, 4'b0110, d, e, b, c);
        send(4'h9, 2'd2, 2'd2, 2'd2, 4'd0, d, e, b, c);
        read_reg(2'd2, v);
        checks++; if (v !== 4'b0011) begin errors++; $display("FAIL lsr_r2 got=%b exp=0011", v); end
        checks++; if (b != 2 || d != 3) begin errors++; $display("FAIL lsr_busy got busy=%0d done@%0d exp 2 3", b, d); end
    endtask

    task automatic test_illegal();
        int d, e, b, c;
        logic [W-1:0] v;
        logic [2:0]   fl;
        send(4'hF, 2'd0, 2'd0, 2'd0, 4'd7, d, e, b, c);
        fl = {m_c, m_n, m_z};
        @(negedge clk);
        bus.instr_op = 4'b1100; bus.instr_rd = 2'd0; bus.instr_ra = 2'd1; bus.instr_rb = 2'd2;
        bus.instr_imm = 4'd0; bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({err, done, bus.instr_ready} !== 3'b101) begin errors++; $display("FAIL illegal_pulse got err,done,ready=%b exp=101", {err, done, bus.instr_ready}); end
        bus.instr_op = 4'hF; bus.instr_rd = 2'd1; bus.instr_imm = 4'd9;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        checks++; if ({bus.instr_ready, err} !== 2'b00) begin errors++; $display("FAIL b2b_accept got ready,err=%b exp=00", {bus.instr_ready, err}); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        model_exec(4'hF, 2'd1, 2'd0, 2'd0, 4'd9);
        read_reg(2'd0, v);
        checks++; if (v !== 4'd7) begin errors++; $display("FAIL illegal_r0 got=%h exp=7", v); end
        read_reg(2'd1, v);
        checks++; if (v !== 4'd9) begin errors++; $display("FAIL b2b_r1 got=%h exp=9", v); end
        checks++; if ({fc, fn, fz} !== fl) begin errors++; $display("FAIL illegal_flags got=%b exp=%b", {fc, fn, fz}, fl); end
    endtask

    task automatic test_reset_mid();
        int d, e, b, c, pulses;
        logic [W-1:0] v;
        send(4'hF, 2'd1, 2'd0, 2'd0, 4'd6, d, e, b, c);
        send(4'hF, 2'd2, 2'd0, 2'd0, 4'd3, d, e, b, c);
        @(negedge clk);
        bus.instr_op = 4'h0; bus.instr_rd = 2'd3; bus.instr_ra = 2'd1; bus.instr_rb = 2'd2;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({done, bus.instr_ready, fc, fn, fz} !== 5'b01000) begin errors++; $display("FAIL midrst_outs got=%b exp=01000", {done, bus.instr_ready, fc, fn, fz}); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin errors++; $display("FAIL midrst_alu got=%h exp=0", {bus.alu_a, bus.alu_b, bus.alu_sel}); end
        pulses = 0;
        repeat (2) begin @(negedge clk); if (done === 1'b1) pulses++; end
        rst = 1'b0;
        model_reset();
        repeat (4) begin @(negedge clk); if (done === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_done got=%0d pulses exp=0", pulses); end
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", bus.instr_ready); end
        read_reg(2'd3, v);
        checks++; if (v !== 4'd0) begin errors++; $display("FAIL midrst_r3 got=%h exp=0", v); end
    endtask

    task automatic test_random();
        int d, e, b, c, exp_d, exp_e;
        logic [3:0]   op;
        logic [1:0]   rd, ra, rb;
        logic [W-1:0] imm, v;
        for (int n = 0; n < 40; n++) begin
            op  = 4'($urandom_range(0, 15));
            rd  = 2'($urandom_range(0, 3));
            ra  = 2'($urandom_range(0, 3));
            rb  = 2'($urandom_range(0, 3));
            imm = W'($urandom);
            exp_d = (op == 4'hF) ? 2 : (op <= 4'd9) ? 3 : 0;
            exp_e = (op == 4'hF || op <= 4'd9) ? 0 : 1;
            send(op, rd, ra, rb, imm, d, e, b, c);
            checks++; if (d != exp_d || e != exp_e || c != 0) begin errors++; $display("FAIL rnd%0d_timing op=%h got done@%0d err@%0d clash=%0d exp %0d %0d 0", n, op, d, e, c, exp_d, exp_e); end
            for (int i = 0; i < 4; i++) begin
                read_reg(2'(i), v);
                checks++; if (v !== m_rf[i]) begin errors++; $display("FAIL rnd%0d_r%0d op=%h got=%h exp=%h", n, i, op, v, m_rf[i]); end
            end
            checks++; if ({fc, fn, fz} !== {m_c, m_n, m_z}) begin errors++; $display("FAIL rnd%0d_flags op=%h got=%b exp=%b", n, op, {fc, fn, fz}, {m_c, m_n, m_z}); end
        end
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_add_carry();
        test_sub_and();
        test_inplace();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
